score_board: RTL and testbench
==============================

SCORE_BOARD -- requirements
Module: score_board

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, meaning number of independent players (1..8).
REQ-002 SHALL have parameter SCORE_W, default 7, meaning width of every score register.
REQ-003 SHALL have parameter MAX_SCORE, default 50, meaning winning score (< 2**SCORE_W).
REQ-004 SHALL have parameter HOLD_CYCLES, default 8, meaning length of the end-of-game flash phase in clk cycles (>= 1).
REQ-005 SHALL have parameter FLASH_PERIOD, default 2, meaning clk cycles per blank toggle during hold (>= 1).
REQ-006 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, a one-cycle pulse that begins a new game.
REQ-009 SHALL have port goodColl, input, N_PLAYERS, a per-player one-cycle point pulse.
REQ-010 SHALL have port badColl, input, N_PLAYERS, a per-player one-cycle elimination pulse.
REQ-011 SHALL have port scores, output, N_PLAYERS*SCORE_W, packed current scores with player 0 in the LSBs.
REQ-012 SHALL have port dispScore, output, SCORE_W, the value for the display.
REQ-013 SHALL have port dispBlank, output, 1, which blanks the display when 1.
REQ-014 SHALL have port winner, output, max(1,$clog2(N_PLAYERS)), the index of the last game's winner.
REQ-015 SHALL have port isGameComplete, output, 1, which is high in states HOLD and DONE.

Function
REQ-016 SHALL implement FSM states IDLE, PLAY, HOLD, DONE.
REQ-017 SHALL, from IDLE or DONE, go to PLAY when start=1, clearing all scores, setting every player alive and clearing the hold counter.
REQ-018 SHALL, in PLAY, increment an alive player's score by 1 on goodColl[p]=1.
REQ-019 SHALL ignore goodColl and badColl for eliminated players, and both inputs entirely outside PLAY.
REQ-020 SHALL, on badColl[p]=1 in PLAY, clear alive[p] and retain score[p]; badColl beats goodColl for the same player in the same cycle, with no increment.
REQ-021 SHALL saturate scores at MAX_SCORE; no increment beyond it and no wrap.
REQ-022 SHALL go PLAY->HOLD in the cycle after any score becomes MAX_SCORE or all players become eliminated, whichever occurs first; simultaneous events across players are all applied in that same cycle.
REQ-023 SHALL latch winner on PLAY->HOLD as the highest score, breaking ties toward the lowest index.
REQ-024 SHALL keep a high-score register that updates in the same cycle any score's next value exceeds it, holds across games, and clears only on reset.
REQ-025 SHALL make HOLD last exactly HOLD_CYCLES cycles and then go to DONE; start is ignored in HOLD.
REQ-026 SHALL set dispScore to the max current score in PLAY, the winner's score in HOLD, and the high score in IDLE and DONE.
REQ-027 SHALL hold dispBlank at 0 except in HOLD, where it is 0 for the first FLASH_PERIOD cycles and then toggles every FLASH_PERIOD cycles.
REQ-028 SHALL drive all outputs from registers only, with no combinational input-to-output path; an input event is visible on the outputs 1 cycle after the edge that samples it.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-game or mid-hold, immediately force: state IDLE, scores 0, high score 0, alive 0, counters 0, dispScore 0, dispBlank 0, winner 0, isGameComplete 0.
REQ-030 SHALL, on rst release, stay in IDLE until start.

Structure
REQ-031 SHALL put the state enum (IDLE, PLAY, HOLD, DONE) and the default parameter constants in the shared package score_pkg.
REQ-032 SHALL place the hold-length counter and flash toggle in one sub-module, flash_timer, with inputs clk, rst, en and outputs done, blank; the FSM and score arithmetic stay in score_board.

Verification
REQ-033 SHALL cover this scenario: reset, start, 3 goodColl on P0 and 1 on P1 -> scores P0=3, P1=1, dispScore=3, isGameComplete=0.
REQ-034 SHALL cover this scenario: goodColl[1] and badColl[1] in the same cycle with P1=4 -> P1 stays 4 and is eliminated; later goodColl[1] is ignored.
REQ-035 SHALL cover this scenario: P0 reaches 50 while P1 is at 10 -> HOLD the next cycle, winner=0, dispScore=50, dispBlank pattern 0,0,1,1,0,0,1,1 over 8 cycles, then DONE with dispScore=50.
REQ-036 SHALL cover this scenario: both players are eliminated in one cycle with scores 7 and 7 -> HOLD, winner=0; a start during HOLD is ignored; a start in DONE gives scores 0 and the high score retained.
REQ-037 SHALL cover this scenario: a second game ends with max 5 and prior high score 50 -> DONE shows 50; further goodColl on P0 at 50 holds at 50.
REQ-038 SHALL cover this scenario: rst asserted in the 4th HOLD cycle -> all outputs 0 asynchronously, state IDLE, high score 0.

Source files
------------

// File: rtl/score_board_pkg.sv
// score_pkg: shared definitions for the score board.
//   state_t            : game FSM states IDLE, PLAY, HOLD, DONE
//   DEF_*              : default values for the score_board parameters
package score_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_N_PLAYERS    = 2;
   localparam int DEF_SCORE_W      = 7;
   localparam int DEF_MAX_SCORE    = 50;
   localparam int DEF_HOLD_CYCLES  = 8;
   localparam int DEF_FLASH_PERIOD = 2;

endpackage

// File: rtl/score_board_flash_timer.sv
// flash_timer: times the end-of-game hold phase and produces the display
// blanking pattern shown during it.
//   clk, rst : clock, asynchronous active-high reset
//   en       : high while the game FSM is in HOLD
//   done     : high in the last cycle of the hold phase (cycle HOLD_CYCLES-1)
//   blank    : registered blank flag; 0 for the first FLASH_PERIOD cycles of
//              the hold phase, then toggles every FLASH_PERIOD cycles
module flash_timer
   import score_pkg::*;
#(
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int FLASH_PERIOD = DEF_FLASH_PERIOD
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic done,
   output logic blank
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam int FL_W  = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

   logic [CNT_W-1:0] hold_cnt;
   logic [FL_W-1:0]  flash_cnt;

   // hold_cnt is the index of the current hold cycle.
   assign done = en && (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

   // blank is the value for the *next* cycle, so it is forced low on the
   // final hold cycle; that keeps it from leaking into DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt  <= '0;
         flash_cnt <= '0;
         blank     <= 1'b0;
      end else if (!en || done) begin
         hold_cnt  <= '0;
         flash_cnt <= '0;
         blank     <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
         if (flash_cnt == FL_W'(FLASH_PERIOD - 1)) begin
            flash_cnt <= '0;
            blank     <= ~blank;
         end else begin
            flash_cnt <= flash_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/score_board.sv
// score_board: multi-player game score keeper with end-of-game display flash.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, starts a game from IDLE or DONE
//   goodColl        : per-player point pulse (PLAY only, alive players only)
//   badColl         : per-player elimination pulse (wins over goodColl)
//   scores          : packed scores, player 0 in the LSBs
//   dispScore       : max score in PLAY, winner's score in HOLD, high score
//                     in IDLE/DONE
//   dispBlank       : display blank flag (flashes during HOLD)
//   winner          : index of the last game's winner
//   isGameComplete  : high in HOLD and DONE
//   state           : current FSM state, for debug/observation
// All outputs are registers; each output register is loaded from the same
// next-state values as the state itself, so an input sampled at an edge is
// reflected on every output right after that edge.
module score_board
   import score_pkg::*;
#(
   parameter int N_PLAYERS    = DEF_N_PLAYERS,
   parameter int SCORE_W      = DEF_SCORE_W,
   parameter int MAX_SCORE    = DEF_MAX_SCORE,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int FLASH_PERIOD = DEF_FLASH_PERIOD
)(
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           start,
   input  logic [N_PLAYERS-1:0]                           goodColl,
   input  logic [N_PLAYERS-1:0]                           badColl,
   output logic [N_PLAYERS*SCORE_W-1:0]                   scores,
   output logic [SCORE_W-1:0]                             dispScore,
   output logic                                           dispBlank,
   output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] winner,
   output logic                                           isGameComplete,
   output state_t                                         state
);

   localparam int WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
   localparam logic [SCORE_W-1:0] MAXV = SCORE_W'(MAX_SCORE);

   state_t               state_q, state_n;
   logic [SCORE_W-1:0]   score_q [N_PLAYERS];
   logic [SCORE_W-1:0]   score_n [N_PLAYERS];
   logic [N_PLAYERS-1:0] alive_q, alive_n;
   logic [SCORE_W-1:0]   high_q, high_n, disp_q, disp_n, best_n;
   logic [WIN_W-1:0]     win_q, win_n, best_idx;
   logic                 complete_q, complete_n;
   logic                 hit_max, hold_done, blank;

   // Score and alive update.
   always_comb begin
      score_n = score_q;
      alive_n = alive_q;
      if ((state_q == IDLE || state_q == DONE) && start) begin
         for (int p = 0; p < N_PLAYERS; p++) score_n[p] = '0;
         alive_n = '1;
      end else if (state_q == PLAY) begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            if (alive_q[p]) begin
               if (badColl[p])
                  alive_n[p] = 1'b0;
               else if (goodColl[p] && score_q[p] < MAXV)
                  score_n[p] = score_q[p] + 1'b1;
            end
         end
      end
   end

   // Max of the next scores; strict '>' keeps the lowest index on ties.
   always_comb begin
      best_n   = '0;
      best_idx = '0;
      hit_max  = 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         if (score_n[p] > best_n) begin
            best_n   = score_n[p];
            best_idx = WIN_W'(p);
         end
         if (score_n[p] == MAXV) hit_max = 1'b1;
      end
   end

   assign high_n = (best_n > high_q) ? best_n : high_q;

   // Next-state and registered-output values.
   always_comb begin
      state_n = state_q;
      win_n   = win_q;
      case (state_q)
         IDLE, DONE: if (start) state_n = PLAY;
         PLAY: begin
            if (hit_max || alive_n == '0) begin
               state_n = HOLD;
               win_n   = best_idx;
            end
         end
         HOLD: if (hold_done) state_n = DONE;
         default: state_n = IDLE;
      endcase
      // Scores are frozen in HOLD, so the max equals the winner's score.
      disp_n     = (state_n == PLAY || state_n == HOLD) ? best_n : high_n;
      complete_n = (state_n == HOLD || state_n == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         for (int p = 0; p < N_PLAYERS; p++) score_q[p] <= '0;
         alive_q    <= '0;
         high_q     <= '0;
         win_q      <= '0;
         disp_q     <= '0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         for (int p = 0; p < N_PLAYERS; p++) score_q[p] <= score_n[p];
         alive_q    <= alive_n;
         high_q     <= high_n;
         win_q      <= win_n;
         disp_q     <= disp_n;
         complete_q <= complete_n;
      end
   end

   flash_timer #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .FLASH_PERIOD (FLASH_PERIOD)
   ) u_flash_timer (
      .clk   (clk),
      .rst   (rst),
      .en    (state_q == HOLD),
      .done  (hold_done),
      .blank (blank)
   );

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
      assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
   end

   assign dispScore      = disp_q;
   assign dispBlank      = blank;
   assign winner         = win_q;
   assign isGameComplete = complete_q;
   assign state          = state_q;

endmodule

// File: tb/tb_score_board.sv
// Bench for score_board: a cycle model predicts every output after each
// driven cycle, the prediction is queued and compared after the edge.
module tb_score_board;
   import score_pkg::*;

   localparam int NP    = 2;
   localparam int SW    = 7;
   localparam int MAXS  = 50;
   localparam int HC    = 8;
   localparam int FP    = 2;
   localparam int WIN_W = 1;

   localparam int O_ST   = 0;
   localparam int O_CMP  = 2;
   localparam int O_WIN  = 3;
   localparam int O_BLK  = O_WIN + WIN_W;
   localparam int O_DISP = O_BLK + 1;
   localparam int O_SC   = O_DISP + SW;
   localparam int EXP_W  = O_SC + NP * SW;

   logic              clk;
   logic              rst;
   logic              start;
   logic [NP-1:0]     goodColl;
   logic [NP-1:0]     badColl;
   logic [NP*SW-1:0]  scores;
   logic [SW-1:0]     dispScore;
   logic              dispBlank;
   logic [WIN_W-1:0]  winner;
   logic              isGameComplete;
   state_t            state;

   score_board dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .goodColl       (goodColl),
      .badColl        (badColl),
      .scores         (scores),
      .dispScore      (dispScore),
      .dispBlank      (dispBlank),
      .winner         (winner),
      .isGameComplete (isGameComplete),
      .state          (state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got=running exp=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int checks;
   int errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   state_t        m_state;
   int            m_score [NP];
   logic [NP-1:0] m_alive;
   int            m_hs;
   int            m_win;
   int            m_hidx;

   task automatic model_reset();
      m_state = IDLE;
      for (int p = 0; p < NP; p++) m_score[p] = 0;
      m_alive = '0;
      m_hs    = 0;
      m_win   = 0;
      m_hidx  = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic st, input logic [NP-1:0] g, input logic [NP-1:0] b);
      logic             end_game;
      logic [EXP_W-1:0] e;
      logic [NP*SW-1:0] sp;
      int               disp;
      int               blk;
      case (m_state)
         IDLE, DONE: begin
            if (st) begin
               for (int p = 0; p < NP; p++) m_score[p] = 0;
               m_alive = '1;
               m_state = PLAY;
            end
         end
         PLAY: begin
            for (int p = 0; p < NP; p++) begin
               if (m_alive[p]) begin
                  if (b[p]) m_alive[p] = 1'b0;
                  else if (g[p] && m_score[p] < MAXS) m_score[p]++;
               end
            end
            end_game = (m_alive == '0);
            for (int p = 0; p < NP; p++) if (m_score[p] == MAXS) end_game = 1'b1;
            if (end_game) begin
               m_state = HOLD;
               m_hidx  = 0;
               m_win   = 0;
               for (int p = 1; p < NP; p++) if (m_score[p] > m_score[m_win]) m_win = p;
            end
         end
         HOLD: begin
            if (m_hidx == HC - 1) m_state = DONE;
            else m_hidx++;
         end
         default: m_state = IDLE;
      endcase
      for (int p = 0; p < NP; p++) if (m_score[p] > m_hs) m_hs = m_score[p];

      blk = (m_state == HOLD) ? ((m_hidx / FP) % 2) : 0;
      if (m_state == PLAY) begin
         disp = 0;
         for (int p = 0; p < NP; p++) if (m_score[p] > disp) disp = m_score[p];
      end else if (m_state == HOLD) begin
         disp = m_score[m_win];
      end else begin
         disp = m_hs;
      end
      for (int p = 0; p < NP; p++) sp[p*SW +: SW] = SW'(m_score[p]);
      e = '0;
      e[O_ST +: 2]      = m_state;
      e[O_CMP]          = (m_state == HOLD || m_state == DONE);
      e[O_WIN +: WIN_W] = WIN_W'(m_win);
      e[O_BLK]          = blk[0];
      e[O_DISP +: SW]   = SW'(disp);
      e[O_SC +: NP*SW]  = sp;
      exp_q.push_back(e);
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic st, input logic [NP-1:0] g, input logic [NP-1:0] b);
      logic [EXP_W-1:0] e;
      @(negedge clk);
      start    = st;
      goodColl = g;
      badColl  = b;
      model_step(st, g, b);
      @(posedge clk);
      #1;
      start    = 1'b0;
      goodColl = '0;
      badColl  = '0;
      e = exp_q.pop_front();
      check("state",    state,          e[O_ST +: 2]);
      check("complete", isGameComplete, e[O_CMP]);
      check("winner",   winner,         e[O_WIN +: WIN_W]);
      check("blank",    dispBlank,      e[O_BLK]);
      check("disp",     dispScore,      e[O_DISP +: SW]);
      check("scores",   scores,         e[O_SC +: NP*SW]);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_scores"}, scores, 0);
      check({tag, "_disp"}, dispScore, 0);
      check({tag, "_blank"}, dispBlank, 0);
      check({tag, "_winner"}, winner, 0);
      check({tag, "_complete"}, isGameComplete, 0);
      check({tag, "_state"}, state, IDLE);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [NP-1:0] rg;
      logic [NP-1:0] rb;
      logic          rs;
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      goodColl = '0;
      badColl  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset("por");
      @(negedge clk);
      rst = 1'b0;

      // Stay idle without start, inputs ignored.
      repeat (2) drive(1'b0, 2'b00, 2'b00);
      drive(1'b0, 2'b11, 2'b11);

      // Game 1: basic scoring, then P0 to 50 with P1 at 10.
      drive(1'b1, 2'b00, 2'b00);
      repeat (3) drive(1'b0, 2'b01, 2'b00);
      drive(1'b0, 2'b10, 2'b00);
      check("g1_p0", scores[SW-1:0], 3);
      check("g1_p1", scores[2*SW-1:SW], 1);
      check("g1_disp3", dispScore, 3);
      check("g1_cmp0", isGameComplete, 0);
      repeat (9) drive(1'b0, 2'b11, 2'b00);
      repeat (38) drive(1'b0, 2'b01, 2'b00);
      check("g1_hold", state, HOLD);
      check("g1_win", winner, 0);
      check("g1_disp50", dispScore, 50);
      check("g1_p1_10", scores[2*SW-1:SW], 10);
      drive(1'b0, 2'b01, 2'b00);           // no increment past 50 in HOLD
      check("g1_sat", scores[SW-1:0], 50);
      drive(1'b1, 2'b00, 2'b00);           // start ignored in HOLD
      repeat (5) drive(1'b0, 2'b00, 2'b00);
      check("g1_last_hold", state, HOLD);
      drive(1'b0, 2'b00, 2'b00);
      check("g1_done", state, DONE);
      check("g1_done_disp", dispScore, 50);

      // Game 2: elimination beats a point, ends with max 5.
      drive(1'b1, 2'b00, 2'b00);
      check("g2_p0_clr", scores, 0);
      repeat (4) drive(1'b0, 2'b10, 2'b00);
      repeat (5) drive(1'b0, 2'b01, 2'b00);
      drive(1'b0, 2'b10, 2'b10);
      check("g2_p1_kept", scores[2*SW-1:SW], 4);
      drive(1'b0, 2'b10, 2'b00);
      check("g2_p1_ign", scores[2*SW-1:SW], 4);
      drive(1'b0, 2'b00, 2'b01);
      check("g2_hold", state, HOLD);
      check("g2_disp5", dispScore, 5);
      repeat (8) drive(1'b0, 2'b00, 2'b00);
      check("g2_done_disp50", dispScore, 50);

      // Game 3: tie at 7, both eliminated together.
      drive(1'b1, 2'b00, 2'b00);
      repeat (7) drive(1'b0, 2'b11, 2'b00);
      drive(1'b0, 2'b00, 2'b11);
      check("g3_hold", state, HOLD);
      check("g3_win_tie", winner, 0);
      drive(1'b1, 2'b00, 2'b00);
      check("g3_start_ign", state, HOLD);
      repeat (7) drive(1'b0, 2'b00, 2'b00);
      check("g3_done", state, DONE);
      drive(1'b1, 2'b00, 2'b00);
      check("g3_restart", scores, 0);

      // Game 4: reset during the 4th hold cycle.
      repeat (2) drive(1'b0, 2'b01, 2'b00);
      drive(1'b0, 2'b00, 2'b11);
      repeat (3) drive(1'b0, 2'b00, 2'b00);
      check("g4_hold4", state, HOLD);
      #1 rst = 1'b1;
      #1 check_reset("async");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (3) drive(1'b0, 2'b00, 2'b00);
      check("g4_hs_clr", dispScore, 0);

      // Random play, with occasional restarts.
      drive(1'b1, 2'b00, 2'b00);
      for (int i = 0; i < 300; i++) begin
         rg = 2'($urandom_range(0, 3));
         rb[0] = ($urandom_range(0, 23) == 0);
         rb[1] = ($urandom_range(0, 23) == 0);
         rs = ($urandom_range(0, 29) == 0);
         drive(rs, rg, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
